// File: rtl/sseg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
// Slot phase encoding, blank bus values and the digit-enable helper.
package sseg_pkg;

  typedef enum logic [1:0] {
    PH_BLANK = 2'd0,
    PH_ON    = 2'd1,
    PH_OFF   = 2'd2
  } phase_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_BLANK  = 4'hF;

  // Active-low enable with only the selected digit low.
  function automatic logic [3:0] an_sel(input logic [1:0] d);
    logic [3:0] v;
    v    = AN_BLANK;
    v[d] = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/sseg_slot_timer.sv
// Digit-slot timebase: cycle count within a slot plus the digit index.
// slot_wrap is high in the first cycle of every slot (count back at 0).
module sseg_slot_timer #(
  parameter int TICK_DIV = 50000,
  parameter int CW       = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [CW-1:0] count,
  output logic [1:0]    digit,
  output logic          slot_wrap
);

  logic last;

  assign last      = (count == CW'(TICK_DIV - 1));
  assign slot_wrap = (count == '0);

  // Count cycles in the slot; step to the next digit on wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      digit <= 2'd0;
    end else if (last) begin
      count <= '0;
      digit <= digit + 2'd1;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/sseg_scan.sv
// Four-digit seven-segment scanner with anti-ghost blanking and PWM.
// Patterns are latched once per frame; brightness once per slot.
module sseg_scan
  import sseg_pkg::*;
#(
  parameter int TICK_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [7:0] sseg0_in,
  input  logic [7:0] sseg1_in,
  input  logic [7:0] sseg2_in,
  input  logic [7:0] sseg3_in,
  input  logic [2:0] bright,
  output logic [7:0] seg_n,
  output logic [3:0] an_n,
  output logic       frame_start
);

  localparam int PWM_STEP = (TICK_DIV - BLANK_CYC) / 8;
  localparam int CW       = $clog2(TICK_DIV);

  logic [CW-1:0]   count;
  logic [1:0]      digit;
  logic            slot_start;
  logic            frame_cap;
  logic [2:0]      b_q;
  logic [2:0]      b_eff;
  logic [3:0][7:0] live;
  logic [3:0][7:0] snap;
  logic [3:0][7:0] snap_eff;
  logic [7:0]      pat;
  logic [CW:0]     cnt_x;
  logic [CW:0]     on_end;
  phase_e          phase;

  sseg_slot_timer #(
    .TICK_DIV (TICK_DIV),
    .CW       (CW)
  ) u_timer (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .count     (count),
    .digit     (digit),
    .slot_wrap (slot_start)
  );

  assign frame_cap = slot_start && (digit == 2'd0);
  assign live      = {sseg3_in, sseg2_in, sseg1_in, sseg0_in};

  // Capture cycle uses live inputs so a zero blank window still works.
  assign b_eff    = slot_start ? bright : b_q;
  assign snap_eff = frame_cap ? live : snap;
  assign pat      = snap_eff[digit];
  assign cnt_x    = {1'b0, count};

  // ON window length scales with brightness code plus one.
  always_comb begin
    on_end = (CW+1)'(BLANK_CYC + (int'(b_eff) + 1) * PWM_STEP);
  end

  // Decode the phase of the current count.
  always_comb begin
    phase = PH_OFF;
    if (cnt_x < (CW+1)'(BLANK_CYC)) begin
      phase = PH_BLANK;
    end else if (cnt_x < on_end) begin
      phase = PH_ON;
    end
  end

  // Latch brightness per slot and the pattern snapshot per frame.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      b_q  <= 3'd0;
      snap <= {4{SEG_BLANK}};
    end else begin
      if (slot_start) b_q  <= bright;
      if (frame_cap)  snap <= live;
    end
  end

  // Registered display drive and frame marker.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      an_n        <= AN_BLANK;
      seg_n       <= SEG_BLANK;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_cap;
      unique case (phase)
        PH_ON: begin
          an_n  <= an_sel(digit);
          seg_n <= pat;
        end
        default: begin
          an_n  <= AN_BLANK;
          seg_n <= SEG_BLANK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sseg_scan.sv
// Self-checking bench for sseg_scan with TICK_DIV=40, BLANK_CYC=8.
// Reference model works from absolute cycle index since reset release.
module tb_sseg_scan;

  localparam int TD = 40;
  localparam int BC = 8;
  localparam int PS = (TD - BC) / 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sg [4];
  logic [2:0] bright;
  logic [7:0] seg_n;
  logic [3:0] an_n;
  logic       frame_start;

  int checks   = 0;
  int failures = 0;

  int         k;
  int         mc;
  int         md;
  int         mb;
  logic [7:0] msnap [4];
  logic [3:0] e_an;
  logic [7:0] e_seg;
  logic       e_fs;

  typedef struct packed {
    logic [3:0][7:0] p;
    logic [2:0]      br;
    logic [7:0]      on_len;
  } vec_t;

  vec_t tbl [4];

  sseg_scan #(
    .TICK_DIV  (TD),
    .BLANK_CYC (BC)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .sseg0_in      (sg[0]),
    .sseg1_in      (sg[1]),
    .sseg2_in      (sg[2]),
    .sseg3_in      (sg[3]),
    .bright        (bright),
    .seg_n         (seg_n),
    .an_n          (an_n),
    .frame_start   (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Model update for one rising edge, using inputs seen at the edge.
  task automatic model_edge();
    if (!rst_n) begin
      k     = 0;
      mc    = 0;
      md    = 0;
      mb    = 0;
      for (int i = 0; i < 4; i++) msnap[i] = 8'hFF;
      e_an  = 4'hF;
      e_seg = 8'hFF;
      e_fs  = 1'b0;
    end else begin
      mc = k % TD;
      md = (k / TD) % 4;
      if (mc == 0) mb = int'(bright);
      if (mc == 0 && md == 0)
        for (int i = 0; i < 4; i++) msnap[i] = sg[i];
      e_fs = (mc == 0 && md == 0);
      if (mc >= BC && mc < BC + (mb + 1) * PS) begin
        e_an     = 4'hF;
        e_an[md] = 1'b0;
        e_seg    = msnap[md];
      end else begin
        e_an  = 4'hF;
        e_seg = 8'hFF;
      end
      k++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("an_n", int'(an_n), int'(e_an));
    chk("seg_n", int'(seg_n), int'(e_seg));
    chk("frame_start", int'(frame_start), int'(e_fs));
    chk("onehot", int'($countones(~an_n) <= 1), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic run_to(int d, int c);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(md == d && mc == c) && n < 400);
    chk("run_to_bound", int'(n < 400), 1);
  endtask

  initial begin
    int on_cnt [4];
    int bad;
    int fs_cnt;
    int on1;

    rst_n  = 1'b0;
    bright = 3'd0;
    for (int i = 0; i < 4; i++) sg[i] = 8'h00;

    tbl[0] = '{p: {8'hB0, 8'hA4, 8'hF9, 8'hC0},
               br: 3'd7, on_len: 8'd32};
    tbl[1] = '{p: {8'hB0, 8'hA4, 8'hF9, 8'hC0},
               br: 3'd0, on_len: 8'd4};
    tbl[2] = '{p: {8'h78, 8'h56, 8'h34, 8'h12},
               br: 3'd3, on_len: 8'd16};
    tbl[3] = '{p: {8'h80, 8'h7F, 8'h00, 8'hFF},
               br: 3'd5, on_len: 8'd24};

    step();
    chk("reset_an", int'(an_n), 4'hF);
    chk("reset_seg", int'(seg_n), 8'hFF);
    chk("reset_fs", int'(frame_start), 0);

    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 4; i++) sg[i] = tbl[v].p[i];
      bright = tbl[v].br;
      do_reset();
      for (int i = 0; i < 4; i++) on_cnt[i] = 0;
      bad    = 0;
      fs_cnt = 0;
      for (int c = 0; c < 4 * TD; c++) begin
        step();
        if (frame_start) fs_cnt++;
        for (int i = 0; i < 4; i++)
          if (!an_n[i]) begin
            on_cnt[i]++;
            if (seg_n != tbl[v].p[i]) bad++;
          end
        if (an_n == 4'hF && seg_n != 8'hFF) bad++;
      end
      for (int i = 0; i < 4; i++)
        chk($sformatf("tbl%0d_on%0d", v, i),
            on_cnt[i], int'(tbl[v].on_len));
      chk($sformatf("tbl%0d_seg", v), bad, 0);
      chk($sformatf("tbl%0d_fs", v), fs_cnt, 1);
    end

    sg[0] = 8'hC0; sg[1] = 8'hF9;
    sg[2] = 8'hA4; sg[3] = 8'hB0;
    bright = 3'd7;
    do_reset();
    run_to(1, 20);
    sg[2] = 8'h99;
    run_to(2, 20);
    chk("tear_an", int'(an_n), 4'hB);
    chk("tear_old", int'(seg_n), 8'hA4);
    run_to(2, 20);
    chk("tear_new", int'(seg_n), 8'h99);
    sg[2] = 8'hA4;

    do_reset();
    run_to(0, 20);
    bright = 3'd1;
    run_to(0, 39);
    chk("br_keep_an", int'(an_n), 4'hE);
    on1 = 0;
    for (int c = 0; c < TD; c++) begin
      step();
      if (an_n != 4'hF) on1++;
    end
    chk("br_next_on", on1, 8);

    bright = 3'd7;
    do_reset();
    run_to(2, 20);
    chk("rst_pre_an", int'(an_n), 4'hB);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_an", int'(an_n), 4'hF);
    chk("rst_async_seg", int'(seg_n), 8'hFF);
    step();
    sg[0] = 8'h92;
    rst_n = 1'b1;
    step();
    chk("rel_fs", int'(frame_start), 1);
    run_to(0, 8);
    chk("rel_an", int'(an_n), 4'hE);
    chk("rel_seg", int'(seg_n), 8'h92);

    do_reset();
    for (int c = 0; c < 1000; c++) begin
      step();
      if ($urandom_range(19) == 0)
        sg[$urandom_range(3)] = 8'($urandom);
      if ($urandom_range(29) == 0)
        bright = 3'($urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
